// File: rtl/axis_upsizer.sv
// Packs consecutive narrow AXI-Stream words into one wide word, lane 0 in the LSBs.
// Lane count per group is runtime-selectable (cfg_data = lanes - 1); tlast closes a group early.
module axis_upsizer #(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int M_AXIS_TDATA_WIDTH = 128
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [15:0]                   cfg_data,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready
);

  localparam int RATIO      = M_AXIS_TDATA_WIDTH / S_AXIS_TDATA_WIDTH;
  localparam int CNTR_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNTR_WIDTH-1:0] LIM_MAX = CNTR_WIDTH'(RATIO - 1);

  logic [CNTR_WIDTH-1:0]         r_cntr;
  logic [CNTR_WIDTH-1:0]         r_lim;
  logic [M_AXIS_TDATA_WIDTH-1:0] r_acc;

  logic [CNTR_WIDTH-1:0]         w_lim;
  logic [CNTR_WIDTH-1:0]         w_lim_eff;
  logic                          w_is_last;
  logic                          w_in_xfer;
  logic                          w_out_xfer;
  logic [M_AXIS_TDATA_WIDTH-1:0] w_merged;

  always_comb begin
    if (cfg_data >= 16'(RATIO - 1)) w_lim = LIM_MAX;
    else                            w_lim = cfg_data[CNTR_WIDTH-1:0];
  end

  // At lane 0 the limit register is not loaded yet, so use the live config directly.
  assign w_lim_eff = (r_cntr == '0) ? w_lim : r_lim;
  assign w_is_last = s_axis_tlast | (r_cntr == w_lim_eff);

  assign s_axis_tready = ~areset & (~m_axis_tvalid | m_axis_tready | ~w_is_last);
  assign w_in_xfer     = s_axis_tvalid & s_axis_tready;
  assign w_out_xfer    = m_axis_tvalid & m_axis_tready;

  always_comb begin
    w_merged = r_acc;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (CNTR_WIDTH'(i) == r_cntr) w_merged[i*S_AXIS_TDATA_WIDTH +: S_AXIS_TDATA_WIDTH] = s_axis_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cntr        <= '0;
      r_lim         <= '0;
      r_acc         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (w_out_xfer) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      if (w_in_xfer) begin
        if (r_cntr == '0) r_lim <= w_lim;
        if (w_is_last) begin
          // Overrides the drain above so a simultaneous drain and load leaves no bubble.
          m_axis_tdata  <= w_merged;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= s_axis_tlast;
          r_acc         <= '0;
          r_cntr        <= '0;
        end else begin
          r_acc  <= w_merged;
          r_cntr <= r_cntr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_upsizer.sv
// Bench for axis_upsizer: a group-level reference model feeds a scoreboard queue,
// and a negedge monitor checks every output handshake, output latency and AXI hold stability.
module tb_axis_upsizer;

  localparam int S = 32;
  localparam int M = 128;
  localparam int RATIO = M / S;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [15:0]   cfg_data = '0;
  logic [S-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [M-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;

  axis_upsizer #(
    .S_AXIS_TDATA_WIDTH(S),
    .M_AXIS_TDATA_WIDTH(M)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_data     (cfg_data),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  bit rnd_ready = 1'b0;

  logic [M-1:0] exp_d[$];
  bit           exp_l[$];
  logic [S-1:0] grp[$];
  int           grp_lanes;
  bit           lat_pending = 1'b0;
  bit           hold_valid = 1'b0;
  logic [M-1:0] hold_data;
  bit           hold_last;

  task automatic chk(input string name, input logic [M-1:0] got, input logic [M-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Reference model: a group is simply the list of accepted words; it closes on tlast
  // or once it holds min(cfg,RATIO-1)+1 words, with cfg taken when the group opens.
  always @(negedge aclk) begin
    if (areset) begin
      grp.delete();
      exp_d.delete();
      exp_l.delete();
      lat_pending = 1'b0;
      hold_valid  = 1'b0;
    end else begin
      if (lat_pending) begin
        chk("latency_valid", m_axis_tvalid, 1'b1);
        lat_pending = 1'b0;
      end
      if (hold_valid) begin
        chk("hold_valid", m_axis_tvalid, 1'b1);
        chk("hold_data", m_axis_tdata, hold_data);
        chk("hold_last", m_axis_tlast, hold_last);
      end
      hold_valid = m_axis_tvalid && !m_axis_tready;
      hold_data  = m_axis_tdata;
      hold_last  = m_axis_tlast;

      if (m_axis_tvalid && m_axis_tready) begin
        n_out++;
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", m_axis_tdata);
        end else begin
          chk("out_data", m_axis_tdata, exp_d.pop_front());
          chk("out_last", m_axis_tlast, exp_l.pop_front());
        end
      end

      if (s_axis_tvalid && s_axis_tready) begin
        if (grp.size() == 0) grp_lanes = (cfg_data >= RATIO - 1) ? RATIO : int'(cfg_data) + 1;
        grp.push_back(s_axis_tdata);
        if (s_axis_tlast || grp.size() == grp_lanes) begin
          logic [M-1:0] e;
          e = '0;
          for (int i = 0; i < grp.size(); i++) e[i*S +: S] = grp[i];
          exp_d.push_back(e);
          exp_l.push_back(s_axis_tlast);
          grp.delete();
          lat_pending = 1'b1;
        end
      end
    end
  end

  always begin
    @(posedge aclk);
    #1;
    if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [S-1:0] d, input bit l, output bit stalled);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    stalled = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      stalled = 1'b1;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got no tready expected tready for word %h", d);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    m_axis_tready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge aclk);
      if (exp_d.size() == 0 && !m_axis_tvalid) begin
        tick();
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending expected 0", exp_d.size());
  endtask

  initial begin
    bit st;
    int stalls;
    int base;

    // Reset state
    repeat (3) tick();
    @(negedge aclk);
    chk("rst_s_tready", s_axis_tready, 1'b0);
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_m_tlast", m_axis_tlast, 1'b0);
    tick();
    areset = 1'b0;

    // Basic packing
    cfg_data = 16'd3;
    send(32'h11, 1'b0, st);
    send(32'h22, 1'b0, st);
    send(32'h33, 1'b0, st);
    send(32'h44, 1'b0, st);
    @(negedge aclk);
    chk("basic_data", m_axis_tdata, 128'h00000044_00000033_00000022_00000011);
    chk("basic_last", m_axis_tlast, 1'b0);
    tick();
    drain();

    // Two lanes per word, back-to-back, never stalled
    cfg_data = 16'd1;
    stalls = 0;
    base = n_out;
    for (int i = 1; i <= 8; i++) begin
      send(S'(i), 1'b0, st);
      stalls += int'(st);
    end
    drain();
    chk("lanecnt_no_stall", stalls, 0);
    chk("lanecnt_outputs", n_out - base, 4);

    // Early close by tlast, then a fresh group starts at lane 0
    cfg_data = 16'd3;
    send(32'hA, 1'b0, st);
    send(32'hB, 1'b1, st);
    @(negedge aclk);
    chk("early_data", m_axis_tdata, 128'h0000000B_0000000A);
    chk("early_last", m_axis_tlast, 1'b1);
    tick();
    for (int i = 1; i <= 4; i++) send(S'(32'hC0 + i), 1'b0, st);
    drain();

    // Backpressure across two groups
    m_axis_tready = 1'b0;
    stalls = 0;
    for (int i = 0; i < 7; i++) begin
      send(S'(32'h100 + i), 1'b0, st);
      stalls += int'(st);
    end
    chk("bp_nonlast_accepted", stalls, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h107;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("bp_last_blocked", s_axis_tready, 1'b0);
      tick();
    end
    m_axis_tready = 1'b1;
    send(32'h107, 1'b0, st);
    drain();

    // Config change mid-group applies to the next group
    base = n_out;
    cfg_data = 16'd3;
    send(32'h201, 1'b0, st);
    send(32'h202, 1'b0, st);
    cfg_data = 16'd0;
    send(32'h203, 1'b0, st);
    send(32'h204, 1'b0, st);
    send(32'h205, 1'b0, st);
    send(32'h206, 1'b0, st);
    drain();
    chk("cfgchg_outputs", n_out - base, 3);

    // Reset in the middle of a group
    cfg_data = 16'd3;
    send(32'h301, 1'b0, st);
    send(32'h302, 1'b0, st);
    areset = 1'b1;
    @(negedge aclk);
    chk("midrst_s_tready", s_axis_tready, 1'b0);
    tick();
    areset = 1'b0;
    @(negedge aclk);
    chk("midrst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_m_tdata", m_axis_tdata, '0);
    tick();
    for (int i = 1; i <= 4; i++) send(S'(32'h400 + i), 1'b0, st);
    @(negedge aclk);
    chk("midrst_clean", m_axis_tdata, 128'h00000404_00000403_00000402_00000401);
    tick();
    drain();

    // Randomized traffic with random backpressure, tlast and config (including saturating values)
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 2) == 0) cfg_data = 16'($urandom);
        else                           cfg_data = 16'($urandom_range(0, 5));
      end
      send($urandom, $urandom_range(0, 7) == 0, st);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    // Flush any open partial group with a closing word
    send(32'hFFFF_0000, 1'b1, st);
    rnd_ready = 1'b0;
    drain();
    chk("final_pending", exp_d.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- Packs consecutive narrow AXI-Stream words into one wide word.
- Sits directly upstream of axis_downsizer; its output is the downsizer's wide input, so a loop through both is data-transparent.
- The lane count per output word is runtime-selectable through cfg_data, using the same encoding as the downsizer (count minus 1).
- A narrow word with tlast closes the group early; the unfilled upper lanes are zero.

Parameters:
- S_AXIS_TDATA_WIDTH, 32, narrow input width.
- M_AXIS_TDATA_WIDTH, 128, wide output width; must be an integer multiple of S_AXIS_TDATA_WIDTH.
- Derived: RATIO = M/S (must be at least 1); CNTR_WIDTH = clog2(RATIO), minimum 1.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset; synchronous, active-high.
- cfg_data  in  16  lanes per output word minus 1; values at or above RATIO-1 saturate to RATIO-1.
- s_axis_tdata  in  S_AXIS_TDATA_WIDTH  narrow input word.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  closes the current group after this word.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  M_AXIS_TDATA_WIDTH  packed output word.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output group was closed by s_axis_tlast.
- m_axis_tready  in  1  output ready.

Behaviour:
- Reset (areset=1 at an edge):
  - lane counter cleared to 0.
  - accumulator cleared to zero.
  - m_axis_tdata cleared to zero; m_axis_tvalid and m_axis_tlast cleared to 0.
  - any partial group is discarded.
  - s_axis_tready is 0 while areset=1.
- Transfers: an input transfer is s_axis_tvalid & s_axis_tready; an output transfer is m_axis_tvalid & m_axis_tready.
- Lane limit:
  - lim = min(cfg_data, RATIO-1).
  - lim is sampled into lim_reg on the transfer of lane 0 of each group.
  - cfg_data changes mid-group take effect on the next group.
- Lane placement:
  - The k-th word accepted in a group (k from 0) goes to bits [k*S +: S]; lane 0 is the LSBs, matching the downsizer's emit order.
  - Lanes above the last filled lane are zero in the emitted word.
- Last lane: the word is the last of its group when cntr == lim_reg (or cntr == 0 and cntr == lim at lane 0), or when s_axis_tlast = 1.
- On a non-last input transfer:
  - the word is written into its accumulator lane;
  - cntr increments by 1.
- On a last input transfer:
  - m_axis_tdata <= accumulator merged with the current word in lane cntr, upper lanes zero;
  - m_axis_tvalid <= 1;
  - m_axis_tlast <= s_axis_tlast;
  - accumulator cleared to zero; cntr <= 0.
- Output transfer with no simultaneous last input transfer: m_axis_tvalid <= 0 and m_axis_tlast <= 0; m_axis_tdata holds its value.
- Output transfer and last input transfer in the same cycle: the new word is loaded, so m_axis_tvalid stays 1. No bubble.
- s_axis_tready = ~areset & (~m_axis_tvalid | m_axis_tready | ~is_last).
  - Non-last lanes are accepted even while the output is stalled.
  - Only the completing word waits for the output slot.
  - This is a combinational path from m_axis_tready to s_axis_tready and is permitted.
- Latency: the completed wide word is valid on the cycle after the last narrow word is accepted.
- Throughput:
  - one narrow word per cycle, sustained, while m_axis_tready=1;
  - one wide word per lim+1 cycles.
- RATIO=1: every input word is a last word; the block acts as a one-stage register slice.
- tlast at lane 0: emits a word with only lane 0 filled and m_axis_tlast=1.
- Once m_axis_tvalid=1, m_axis_tdata and m_axis_tlast are stable until the output transfer completes (AXI rule).

Test Plan:
- Basic packing: cfg=3, words 0x11,0x22,0x33,0x44, m_tready=1 -> one output 0x00000044_00000033_00000022_00000011 one cycle after 0x44 is accepted; m_tlast=0.
- Lane count: cfg=1, eight words 1..8 streamed back-to-back -> four outputs 0x..0_00000002_00000001 through 0x..0_00000008_00000007, upper 64 bits zero; s_tready stays 1 throughout.
- Early close: cfg=3, words 0xA,0xB with tlast on 0xB -> output 0x0..0_0000000B_0000000A with m_tlast=1; the next group starts at lane 0.
- Backpressure: cfg=3, hold m_tready=0 through two full groups -> the first output is held stable; the second group's lanes 0-2 are accepted; s_tready=0 on lane 3 until m_tready=1; no loss or duplication; simultaneous drain and load produces no bubble.
- Config change mid-group: cfg=3 at lane 0, then cfg=0 after lane 1 -> the current group still completes with 4 lanes; subsequent outputs carry one lane each.
- Reset mid-group: two words accepted, areset pulsed for 1 cycle -> m_tvalid=0, m_tdata=0, partial data discarded; the next 4 words form a clean output.
